// File: rtl/fb_sched_pkg.sv
// Shared types and constants for the framebuffer draw scheduler.
package fb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SERVE = 2'd2,
    END   = 2'd3
  } state_t;

  localparam int FB_COORD_W = 11;

  // Requester slots, in the order they are served each frame.
  localparam int REQ_CLEAR = 0;
  localparam int REQ_PIPE1 = 1;
  localparam int REQ_PIPE2 = 2;
  localparam int REQ_BIRD  = 3;

endpackage

// File: rtl/tick_edge_sync.sv
// Brings the free-running game tick into the clk domain and flags its rising edge.
module tick_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  output logic rise_o
);

  logic [2:0] sync_q;

  // two metastability flops plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], tick_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/fb_draw_scheduler.sv
// Per-frame sequencer and arbiter for the single framebuffer write port.
// Optional watchdog on the SERVE state: define FB_SCHED_WATCHDOG_EN.
//
// state | meaning
// IDLE  | waiting for a game tick
// SCAN  | checking req[idx], one cycle per slot
// SERVE | grant held for requester idx until done (or watchdog)
// END   | frame_done pulse, busy cleared
module fb_draw_scheduler
  import fb_sched_pkg::*;
#(
  parameter int NUM_REQ = REQ_BIRD + 1,
  parameter int COORD_W = FB_COORD_W,
  parameter int OVR_W   = 8,
  parameter int TIMEOUT = 2**20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  input  logic [NUM_REQ-1:0]         req_color,
  input  logic [NUM_REQ-1:0]         req_wr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [COORD_W-1:0]         fb_x,
  output logic [COORD_W-1:0]         fb_y,
  output logic                       fb_color,
  output logic                       fb_write,
  output logic                       busy,
  output logic                       frame_done,
  output logic [OVR_W-1:0]           overrun_cnt,
  output logic                       timeout_flag
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic               frame_done_q;
  logic [OVR_W-1:0]   overrun_q;
  logic               tick_rise;
  logic               wd_expired;
  logic               serve_end;

  tick_edge_sync u_tick_sync (
    .clk    (clk),
    .rst_n  (reset),
    .tick_i (tick),
    .rise_o (tick_rise)
  );

`ifdef FB_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  // abort only if done has not arrived in the final allowed cycle
  assign wd_expired = (state_q == SERVE) && (wd_q == '0) && !done[idx_q];

  // watchdog down-counter, reloaded on every new grant; abort flag is sticky
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == SCAN && req[idx_q]) begin
        wd_q <= WD_W'(TIMEOUT - 1);
      end else if (state_q == SERVE && wd_q != '0) begin
        wd_q <= wd_q - 1'b1;
      end
      if (wd_expired) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign wd_expired   = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign serve_end = done[idx_q] | wd_expired;

  // frame sequencing, grant generation and overrun accounting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;
      // a tick that cannot start a frame is dropped and counted, saturating
      if (tick_rise && state_q != IDLE && overrun_q != '1) begin
        overrun_q <= overrun_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (tick_rise) begin
            state_q <= SCAN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (req[idx_q]) begin
            state_q <= SERVE;
            grant_q <= NUM_REQ'(1) << idx_q;
          end else if (idx_q == LAST_IDX) begin
            state_q      <= END;
            frame_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        SERVE: begin
          if (serve_end) begin
            grant_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q      <= END;
              frame_done_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= SCAN;
            end
          end
        end
        END: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // zero-latency pixel mux from the granted requester; all zero without a grant
  always_comb begin
    fb_x     = '0;
    fb_y     = '0;
    fb_color = 1'b0;
    fb_write = 1'b0;
    if (grant_q[idx_q]) begin
      fb_x     = req_x[int'(idx_q) * COORD_W +: COORD_W];
      fb_y     = req_y[int'(idx_q) * COORD_W +: COORD_W];
      fb_color = req_color[idx_q];
      fb_write = req_wr[idx_q];
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_fb_draw_scheduler.sv
// Scoreboard bench for fb_draw_scheduler: directed frames push expected grants
// and frame summaries; a monitor pops and compares as the DUT produces them.
module tb_fb_draw_scheduler;

`ifdef FB_SCHED_WATCHDOG_EN
  localparam int TO = 16;
`else
  localparam int TO = 2**20;
`endif
  localparam int DONE_L = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [43:0] req_x;
  logic [43:0] req_y;
  logic [3:0]  req_color;
  logic [3:0]  req_wr;
  logic [3:0]  grant;
  logic [10:0] fb_x;
  logic [10:0] fb_y;
  logic        fb_color;
  logic        fb_write;
  logic        busy;
  logic        frame_done;
  logic [7:0]  overrun_cnt;
  logic        timeout_flag;

  logic [10:0] x_tab [4];
  logic [10:0] y_tab [4];
  logic [3:0]  hold_done;

  typedef struct {
    int grants;
    int cycles;
  } frame_t;

  int     exp_grant_q[$];
  frame_t exp_frame_q[$];
  int     total = 0;
  int     bad = 0;

  fb_draw_scheduler #(
    .NUM_REQ (4),
    .COORD_W (11),
    .OVR_W   (8),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .req          (req),
    .done         (done),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_color    (req_color),
    .req_wr       (req_wr),
    .grant        (grant),
    .fb_x         (fb_x),
    .fb_y         (fb_y),
    .fb_color     (fb_color),
    .fb_write     (fb_write),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun_cnt  (overrun_cnt),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < 4; i++) begin
      req_x[i*11 +: 11] = x_tab[i];
      req_y[i*11 +: 11] = y_tab[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // requester model: raise done after DONE_L granted cycles unless held off
  int dcnt [4];
  initial begin
    done = '0;
    for (int i = 0; i < 4; i++) dcnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (reset === 1'b1 && grant[i] && !hold_done[i]) begin
          dcnt[i]++;
          done[i] = (dcnt[i] >= DONE_L);
        end else begin
          dcnt[i] = 0;
          done[i] = 1'b0;
        end
      end
    end
  end

  // monitor: pops expected grants/frames as the DUT produces them
  int          mon_grants;
  int          mon_busy_cyc;
  logic [3:0]  prev_grant;
  logic        prev_fd;
  int          e_idx;
  frame_t      e_fr;
  logic [10:0] ex_x, ex_y;
  logic        ex_c, ex_w;
  initial begin
    mon_grants = 0; mon_busy_cyc = 0; prev_grant = '0; prev_fd = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        mon_grants = 0; mon_busy_cyc = 0; prev_grant = '0; prev_fd = 1'b0;
      end else begin
        if (grant != 4'b0 && prev_grant == 4'b0) begin
          mon_grants++;
          chk("grant_onehot", 32'($onehot(grant)), 32'd1);
          if (exp_grant_q.size() == 0) begin
            chk("grant_unexpected", 32'(grant), 32'd0);
          end else begin
            e_idx = exp_grant_q.pop_front();
            chk("grant_order", 32'(grant), 32'd1 << e_idx);
          end
        end
        ex_x = '0; ex_y = '0; ex_c = 1'b0; ex_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (grant[i]) begin
            ex_x = x_tab[i]; ex_y = y_tab[i]; ex_c = req_color[i]; ex_w = req_wr[i];
          end
        end
        chk("fb_x", 32'(fb_x), 32'(ex_x));
        chk("fb_y", 32'(fb_y), 32'(ex_y));
        chk("fb_color", 32'(fb_color), 32'(ex_c));
        chk("fb_write", 32'(fb_write), 32'(ex_w));
        if (prev_fd) chk("busy_after_frame", 32'(busy), 32'd0);
        if (frame_done) begin
          if (exp_frame_q.size() == 0) begin
            chk("frame_unexpected", 32'(frame_done), 32'd0);
          end else begin
            e_fr = exp_frame_q.pop_front();
            chk("frame_grants", 32'(mon_grants), 32'(e_fr.grants));
            if (e_fr.cycles >= 0) chk("frame_cycles", 32'(mon_busy_cyc), 32'(e_fr.cycles));
          end
          mon_grants = 0;
          mon_busy_cyc = 0;
        end else if (busy) begin
          mon_busy_cyc++;
        end
        prev_grant = grant;
        prev_fd = frame_done;
      end
    end
  end

  task automatic wait_grant(input logic [3:0] mask, input string name);
    int n = 0;
    while (grant !== mask && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(name, 32'(grant), 32'(mask));
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while (frame_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk(name, 32'(frame_done), 32'd1);
  endtask

  task automatic run_frame(input logic [3:0] r, input string name);
    req = r;
    tick = 1'b1;
    @(negedge clk);
    wait_frame(name);
    tick = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    repeat (5) @(negedge clk);
    tick = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #500us;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    reset = 1'b0; tick = 1'b0; req = '0; req_color = 4'b1010; req_wr = '0;
    hold_done = '0;
    x_tab[0] = 11'd10;  y_tab[0] = 11'd20;
    x_tab[1] = 11'd100; y_tab[1] = 11'd200;
    x_tab[2] = 11'd5;   y_tab[2] = 11'd6;
    x_tab[3] = 11'd40;  y_tab[3] = 11'd77;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(overrun_cnt), 32'd0);
    chk("rst_timeout", 32'(timeout_flag), 32'd0);
    chk("rst_fb_write", 32'(fb_write), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // all four requesters, served in fixed order: 4 SCAN + 4*5 SERVE cycles
    req_wr = 4'b0101;
    exp_grant_q.push_back(0); exp_grant_q.push_back(1);
    exp_grant_q.push_back(2); exp_grant_q.push_back(3);
    exp_frame_q.push_back('{4, 24});
    run_frame(4'b1111, "t1_frame_timeout");
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // sparse requests: slots 0 and 2 skipped in one cycle each
    req_wr = 4'b1111;
    exp_grant_q.push_back(1); exp_grant_q.push_back(3);
    exp_frame_q.push_back('{2, 14});
    run_frame(4'b1010, "t2_frame_timeout");

    // empty frame: four SCAN cycles then END; writes from nobody reach the port
    exp_frame_q.push_back('{0, 4});
    run_frame(4'b0000, "t3_frame_timeout");

    // granted pixel fields appear on the port in the grant cycle
    x_tab[2] = 11'd319; y_tab[2] = 11'd250;
    req_wr = 4'b1111;
    exp_grant_q.push_back(2);
    exp_frame_q.push_back('{1, 9});
    req = 4'b0100;
    tick = 1'b1;
    wait_grant(4'b0100, "t5_grant_timeout");
    chk("t5_fb_x", 32'(fb_x), 32'd319);
    chk("t5_fb_y", 32'(fb_y), 32'd250);
    chk("t5_fb_write", 32'(fb_write), 32'd1);
    wait_frame("t5_frame_timeout");
    tick = 1'b0;
    repeat (6) @(negedge clk);

`ifndef FB_SCHED_WATCHDOG_EN
    // ticks during a stalled frame are counted and saturate
    req_wr = 4'b0010;
    hold_done = 4'b0010;
    exp_grant_q.push_back(1);
    exp_frame_q.push_back('{1, -1});
    req = 4'b0010;
    tick = 1'b1;
    wait_grant(4'b0010, "t4_grant_timeout");
    tick = 1'b0;
    repeat (5) @(negedge clk);
    repeat (3) pulse_tick();
    chk("t4_overrun3", 32'(overrun_cnt), 32'd3);
    repeat (260) pulse_tick();
    chk("t4_overrun_sat", 32'(overrun_cnt), 32'd255);
    chk("t4_still_granted", 32'(grant), 32'b0010);
    hold_done = '0;
    wait_frame("t4_frame_timeout");
    repeat (6) @(negedge clk);
`endif

    // reset mid-SERVE: grant drops without a clock, no frame_done afterwards
    hold_done = 4'b0001;
    exp_grant_q.push_back(0);
    req = 4'b0001;
    tick = 1'b1;
    wait_grant(4'b0001, "t6_grant_timeout");
    tick = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_grant_async", 32'(grant), 32'd0);
    chk("t6_fb_x_async", 32'(fb_x), 32'd0);
    chk("t6_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    hold_done = '0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_done) n++;
    end
    chk("t6_no_frame_done", 32'(n), 32'd0);
    chk("t6_overrun_cleared", 32'(overrun_cnt), 32'd0);

`ifdef FB_SCHED_WATCHDOG_EN
    // stuck requester: grant held exactly TO cycles, then frame continues
    hold_done = 4'b0001;
    exp_grant_q.push_back(0);
    exp_frame_q.push_back('{1, 4 + TO});
    req = 4'b0001;
    tick = 1'b1;
    wait_grant(4'b0001, "wd_grant_timeout");
    tick = 1'b0;
    n = 0;
    while (grant[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("wd_grant_cycles", 32'(n), 32'(TO));
    chk("wd_timeout_flag", 32'(timeout_flag), 32'd1);
    wait_frame("wd_frame_timeout");
    hold_done = '0;
    repeat (6) @(negedge clk);
    chk("wd_flag_sticky", 32'(timeout_flag), 32'd1);
`endif

    chk("grants_drained", 32'(exp_grant_q.size()), 32'd0);
    chk("frames_drained", 32'(exp_frame_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
